// File: rtl/ising_energy_stream.sv
// Streaming Ising energy evaluator.
// J is streamed in column chunks of COLS_PER_BEAT columns, each covering all rows.
// Stage 1 reduces one beat to a signed partial energy.
// Stage 2 accumulates the partials.
// An optional early stop ends the run once the accumulated energy can no longer
// fall to or below energy_prev.
module ising_energy_stream #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int COLS_PER_BEAT   = 4,
  parameter int J_SIGNED        = 0,
  parameter int ENERGY_WIDTH    = J_ELEMENT_WIDTH + 2*$clog2(VECTOR_SIZE) + 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic [VECTOR_SIZE-1:0]                                 sigma,
  input  logic signed [ENERGY_WIDTH-1:0]                         energy_prev,
  input  logic                                                   early_stop_en,
  input  logic                                                   j_valid,
  output logic                                                   j_ready,
  input  logic [VECTOR_SIZE*COLS_PER_BEAT*J_ELEMENT_WIDTH-1:0]   j_data,
  output logic [$clog2(VECTOR_SIZE/COLS_PER_BEAT)-1:0]           chunk_idx,
  output logic                                                   busy,
  output logic                                                   done,
  output logic signed [ENERGY_WIDTH-1:0]                         energy,
  output logic                                                   aborted
);

  localparam int N      = VECTOR_SIZE;
  localparam int W      = J_ELEMENT_WIDTH;
  localparam int C      = COLS_PER_BEAT;
  localparam int CHUNKS = N / C;
  localparam int IDX_W  = $clog2(CHUNKS);
  localparam int CNT_W  = $clog2(CHUNKS + 1);
  localparam int SIG_W  = $clog2(N);
  localparam int JIDX_W = $clog2(N*C*W);
  // One beat partial is bounded by C*N*max|J|; two extra bits cover the sign
  // and the signed-minimum magnitude.
  localparam int P_W    = W + $clog2(N) + $clog2(C) + 2;
  // The early-stop margin spans acc minus the full remaining bound.
  localparam int CMP_W  = ENERGY_WIDTH + 2;
  localparam int JMAX   = (J_SIGNED != 0) ? (1 << (W-1)) : ((1 << W) - 1);
  localparam logic signed [CMP_W-1:0] BEAT_MAX = CMP_W'(C*N*JMAX);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [N-1:0]               sigma_q;
  logic signed [P_W-1:0]      part_sum;
  logic signed [P_W-1:0]      part_p1;
  logic                       vld_p1;
  logic signed [ENERGY_WIDTH-1:0] acc;
  logic [CNT_W-1:0]           acc_cnt;
  logic                       hs;
  logic                       run_start;
  logic                       last_beat;
  logic                       abort_now;
  logic signed [CMP_W-1:0]    remain;
  logic signed [CMP_W-1:0]    bound;
  logic signed [CMP_W-1:0]    margin;
  logic [SIG_W-1:0]           col_i;

  function automatic logic signed [P_W-1:0] ext_j(input logic [W-1:0] j);
    if (J_SIGNED != 0) return P_W'(signed'(j));
    else               return P_W'({1'b0, j});
  endfunction

  assign hs        = j_valid && j_ready;
  assign run_start = (state_q == S_IDLE) && start;
  assign last_beat = (chunk_idx == IDX_W'(CHUNKS - 1));
  assign energy    = acc;

  // Beat reduction: each element contributes +J when its row and column spins agree, -J otherwise.
  always_comb begin
    part_sum = '0;
    col_i    = '0;
    for (int k = 0; k < C; k++) begin
      col_i = SIG_W'(int'(chunk_idx) * C + k);
      for (int r = 0; r < N; r++) begin
        if (sigma_q[SIG_W'(r)] == sigma_q[col_i])
          part_sum = part_sum + ext_j(j_data[JIDX_W'(((r*C)+k)*W) +: W]);
        else
          part_sum = part_sum - ext_j(j_data[JIDX_W'(((r*C)+k)*W) +: W]);
      end
    end
  end

  // Early-stop test: even if every remaining beat were maximally negative, acc stays above the threshold.
  always_comb begin
    remain    = CMP_W'(CHUNKS) - CMP_W'(acc_cnt);
    bound     = remain * BEAT_MAX;
    margin    = CMP_W'(acc) - bound;
    abort_now = early_stop_en && (acc_cnt != '0) &&
                ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                (margin > CMP_W'(energy_prev));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    j_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_STREAM;
      end
      S_STREAM: begin
        j_ready = 1'b1;
        if (abort_now)              state_d = S_DONE;
        else if (hs && last_beat)   state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --- stage 1 / stage 2 control and accumulator ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_idx <= '0;
      aborted   <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
      vld_p1    <= 1'b0;
    end else if (run_start) begin
      chunk_idx <= '0;
      aborted   <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (hs) chunk_idx <= chunk_idx + IDX_W'(1);
      vld_p1 <= hs && !abort_now;
      if (vld_p1 && !abort_now) begin
        acc     <= acc + ENERGY_WIDTH'(part_p1);
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (abort_now) aborted <= 1'b1;
    end
  end

  // --- stage 1 data: spin snapshot and beat partial ---
  always_ff @(posedge clk) begin
    if (run_start) sigma_q <= sigma;
    if (hs)        part_p1 <= part_sum;
  end

endmodule

// File: tb/tb_ising_energy_stream.sv
// Bench for ising_energy_stream.
// Runs two instances, one with unsigned J and one with signed J.
// The driver queues the expected result of each run at start.
// The monitor compares that result when done pulses.
module tb_ising_energy_stream;

  localparam int N  = 256;
  localparam int C  = 4;
  localparam int W  = 4;
  localparam int EW = 22;
  localparam int CH = N / C;
  localparam int DW = N * C * W;

  typedef struct {
    longint e;
    bit     ab;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 start_u, start_s;
  logic [N-1:0]         sigma;
  logic signed [EW-1:0] energy_prev;
  logic                 early_stop_en;
  logic                 j_valid;
  logic [DW-1:0]        j_data;

  logic                 jr_u, busy_u, done_u, ab_u;
  logic [5:0]           ci_u;
  logic signed [EW-1:0] en_u;
  logic                 jr_s, busy_s, done_s, ab_s;
  logic [5:0]           ci_s;
  logic signed [EW-1:0] en_s;

  logic [W-1:0] jmat [N][N];
  exp_t q_u[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ising_energy_stream dut_u (
    .clk(clk), .rst(rst), .start(start_u), .sigma(sigma), .energy_prev(energy_prev),
    .early_stop_en(early_stop_en), .j_valid(j_valid), .j_ready(jr_u), .j_data(j_data),
    .chunk_idx(ci_u), .busy(busy_u), .done(done_u), .energy(en_u), .aborted(ab_u)
  );

  ising_energy_stream #(.J_SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .sigma(sigma), .energy_prev(energy_prev),
    .early_stop_en(early_stop_en), .j_valid(j_valid), .j_ready(jr_s), .j_data(j_data),
    .chunk_idx(ci_s), .busy(busy_s), .done(done_s), .energy(en_s), .aborted(ab_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] make_beat(input int b);
    logic [DW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < C; k++)
        v[((r*C)+k)*W +: W] = jmat[r][b*C+k];
    return v;
  endfunction

  function automatic longint golden(input logic [N-1:0] sg, input bit sgn);
    longint e, col, jv;
    e = 0;
    for (int c = 0; c < N; c++) begin
      col = 0;
      for (int r = 0; r < N; r++) begin
        jv  = sgn ? longint'($signed(jmat[r][c])) : longint'(jmat[r][c]);
        col = col + (sg[r] ? jv : -jv);
      end
      e = e + (sg[c] ? col : -col);
    end
    return e;
  endfunction

  task automatic fill_j(input logic [W-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        jmat[r][c] = v;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_energy"},  en_u,   0);
    chk({tag, "_aborted"}, ab_u,   0);
    chk({tag, "_done"},    done_u, 0);
    chk({tag, "_busy"},    busy_u, 0);
    chk({tag, "_j_ready"}, jr_u,   0);
    chk({tag, "_chunk"},   ci_u,   0);
  endtask

  // vmode: 0 valid held, 1 valid every other cycle, 2 random valid.
  task automatic run(input int d, input logic [N-1:0] sg, input bit es, input longint prev,
                     input int vmode, input bit push, input longint exp_e, input bit exp_ab,
                     input int rst_at, input int start_at);
    int   b, cyc;
    bit   jv, hs, did_start;
    exp_t ex;
    sigma         = sg;
    early_stop_en = es;
    energy_prev   = EW'(prev);
    ex.e  = exp_e;
    ex.ab = exp_ab;
    if (push) begin
      if (d == 0) q_u.push_back(ex);
      else        q_s.push_back(ex);
    end
    if (d == 0) start_u = 1'b1;
    else        start_s = 1'b1;
    step;
    start_u = 1'b0;
    start_s = 1'b0;
    b = 0;
    cyc = 0;
    did_start = 1'b0;
    while (b < CH && cyc < 1000 && ((d == 0) ? busy_u : busy_s)) begin
      start_u = 1'b0;
      start_s = 1'b0;
      if (b == rst_at) begin
        j_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("midrun_rst");
        step;
        rst = 1'b0;
        step;
        return;
      end
      if (b == start_at && !did_start) begin
        did_start = 1'b1;
        if (d == 0) start_u = 1'b1;
        else        start_s = 1'b1;
        sigma = ~sg;
      end
      case (vmode)
        0:       jv = 1'b1;
        1:       jv = (cyc % 2 == 0);
        default: jv = 1'($urandom_range(0, 1));
      endcase
      j_valid = jv;
      j_data  = make_beat(b);
      hs = jv && ((d == 0) ? jr_u : jr_s);
      step;
      cyc++;
      if (hs) b++;
    end
    j_valid = 1'b0;
    start_u = 1'b0;
    start_s = 1'b0;
    chk("stream_budget", (cyc < 1000), 1);
    cyc = 0;
    while (((d == 0) ? busy_u : busy_s) && cyc < 20) begin
      step;
      cyc++;
    end
    chk("idle_budget", ((d == 0) ? busy_u : busy_s), 0);
  endtask

  // Monitor: tracks handshakes per instance and scores each done pulse.
  int                   hs_cnt [2];
  int                   last_hs[2];
  int                   cyc_n = 0;
  logic                 m_rdy, m_bsy, m_dn, m_ab, m_st;
  logic [5:0]           m_ci;
  logic signed [EW-1:0] m_en;
  exp_t                 m_exp;
  int                   m_qs;

  always @(negedge clk) begin
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      m_rdy = (d == 0) ? jr_u    : jr_s;
      m_bsy = (d == 0) ? busy_u  : busy_s;
      m_dn  = (d == 0) ? done_u  : done_s;
      m_ab  = (d == 0) ? ab_u    : ab_s;
      m_st  = (d == 0) ? start_u : start_s;
      m_ci  = (d == 0) ? ci_u    : ci_s;
      m_en  = (d == 0) ? en_u    : en_s;
      if (rst) begin
        hs_cnt[d] = 0;
      end else begin
        if (m_st && !m_bsy) hs_cnt[d] = 0;
        if (j_valid && m_rdy) begin
          chk("chunk_idx", m_ci, hs_cnt[d]);
          hs_cnt[d]++;
          last_hs[d] = cyc_n;
        end
        if (m_dn) begin
          m_qs = (d == 0) ? q_u.size() : q_s.size();
          chk("done_expected", (m_qs > 0), 1);
          if (m_qs > 0) begin
            m_exp = (d == 0) ? q_u.pop_front() : q_s.pop_front();
            chk("energy",  m_en, m_exp.e);
            chk("aborted", m_ab, m_exp.ab);
            if (!m_exp.ab) begin
              chk("handshakes",   hs_cnt[d], CH);
              chk("done_latency", cyc_n - last_hs[d], 2);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] sg;
    longint       ex;
    rst = 1'b1;
    start_u = 1'b0;
    start_s = 1'b0;
    sigma = '0;
    energy_prev = '0;
    early_stop_en = 1'b0;
    j_valid = 1'b0;
    j_data = '0;
    hs_cnt = '{0, 0};
    last_hs = '{0, 0};
    repeat (3) step;
    check_reset_state("reset");
    rst = 1'b0;
    repeat (2) step;

    fill_j(4'd15);
    run(0, '1, 0, 0, 0, 1, 983040, 0, -1, -1);
    run(0, {128{2'b10}}, 0, 0, 0, 1, 0, 0, -1, -1);
    run(0, '1, 0, 0, 1, 1, 983040, 0, -1, -1);
    run(0, '1, 1, 0, 0, 1, 506880, 1, -1, -1);
    run(0, '1, 1, 983040, 0, 1, 983040, 0, -1, -1);

    fill_j(4'b1000);
    run(1, '0, 0, 0, 0, 1, -524288, 0, -1, -1);

    fill_j(4'd15);
    run(0, '1, 0, 0, 0, 0, 0, 0, 20, -1);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        jmat[r][c] = 4'($urandom_range(0, 15));
    for (int i = 0; i < N/32; i++) sg[i*32 +: 32] = $urandom;
    ex = golden(sg, 0);
    run(0, sg, 0, 0, 2, 1, ex, 0, -1, 30);

    for (int i = 0; i < N/32; i++) sg[i*32 +: 32] = $urandom;
    ex = golden(sg, 1);
    run(1, sg, 0, 0, 1, 1, ex, 0, -1, 10);

    repeat (5) step;
    chk("pending_u", q_u.size(), 0);
    chk("pending_s", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ising_energy_stream.md
ISING_ENERGY_STREAM -- requirements
Module: ising_energy_stream

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 256: spin count N (power of two).
REQ-002 SHALL have parameter J_ELEMENT_WIDTH, default 4: bits per J element W.
REQ-003 SHALL have parameter COLS_PER_BEAT, default 4: J columns per beat C (power of two, divides N).
REQ-004 SHALL have parameter J_SIGNED, default 0: 0 = J unsigned, 1 = J two's complement.
REQ-005 SHALL have parameter ENERGY_WIDTH, default W+2*clog2(N)+2 (22): signed energy width.
REQ-006 SHALL be one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 start  input  1  single-cycle run request.
REQ-010 sigma  input  N  spin vector; bit 1 = +1, bit 0 = -1.
REQ-011 energy_prev  input  ENERGY_WIDTH  signed early-stop threshold.
REQ-012 early_stop_en  input  1  enables early termination.
REQ-013 j_valid  input  1  J beat valid.
REQ-014 j_ready  output  1  J beat accepted when j_valid and j_ready are both high.
REQ-015 j_data  input  N*C*W  element (row r, col k) at bits [((r*C)+k)*W +: W]; absolute column = chunk_idx*C+k.
REQ-016 chunk_idx  output  clog2(N/C)  index of the beat currently requested.
REQ-017 busy  output  1  run in progress.
REQ-018 done  output  1  one-cycle pulse at run end.
REQ-019 energy  output  ENERGY_WIDTH  signed result, held until next start.
REQ-020 aborted  output  1  last run ended by early stop; held until next start.

Function
REQ-021 SHALL compute E = sum_c s_c * sum_r s_r*J[r][c], with s = +1/-1 from sigma and J per J_SIGNED.
REQ-022 SHALL use FSM IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-023 IDLE: start latches sigma, clears the accumulator, chunk_idx, aborted and the beat counter, then enters STREAM; sigma changes after latch SHALL be ignored.
REQ-024 start while busy SHALL be ignored.
REQ-025 j_ready SHALL be high only in STREAM; chunk_idx SHALL advance only on handshake; stalls (j_valid low) SHALL not alter results.
REQ-026 Stage 1 SHALL register the beat partial P = sum_k s_(chunk*C+k) * column dot-product (signed, exact); stage 2 SHALL add P into the accumulator.
REQ-027 After the N/C-th handshake, STREAM -> DRAIN; done SHALL pulse exactly 2 cycles after the final handshake, with energy valid in the same cycle.
REQ-028 Early stop: when stage 2 has accumulated k beats, with BEAT_MAX = C*N*max|J| (2^W-1 unsigned, 2^(W-1) signed), the FSM SHALL abort if early_stop_en=1 and acc_k - (N/C-k)*BEAT_MAX > energy_prev (signed compare).
REQ-029 On abort: FSM -> DONE next cycle, j_ready low from that cycle, in-flight partials dropped, energy = acc_k, aborted=1.
REQ-030 Intermediate arithmetic SHALL be wide enough that no overflow occurs for any legal input; the bound product SHALL not wrap.
REQ-031 busy SHALL be high in STREAM, DRAIN and DONE.

Reset
REQ-032 rst SHALL, asynchronously and at any time including mid-run, force IDLE, energy=0, aborted=0, done=0, busy=0, j_ready=0, chunk_idx=0, and clear the pipeline.
REQ-033 The first run after reset deassertion SHALL be unaffected by any run that was interrupted.

Verification
REQ-034 Defaults, J all 15, sigma all 1, j_valid held high -> energy=983040, done 2 cycles after beat 64, aborted=0.
REQ-035 J all 15, sigma = 1010... pattern -> energy=0.
REQ-036 J_SIGNED=1, J all 4'b1000, sigma all 0 -> energy=-524288.
REQ-037 Same as REQ-034 with j_valid toggled every other cycle -> energy=983040, exactly 64 handshakes, chunk_idx sequence 0..63 with no skips.
REQ-038 REQ-034 stimulus, early_stop_en=1, energy_prev=0 -> abort after 33 beats accumulated, energy=506880, aborted=1; energy_prev=983040 -> no abort.
REQ-039 rst pulsed at beat 20 of a run, then random J/sigma run -> energy matches the golden model; start asserted mid-run has no effect.
